// File: rtl/riscv_pkg.sv
// Shared encodings for the RV32I-subset multi-cycle controller:
// opcodes, funct3 values, FSM states and datapath select codes.
package riscv_pkg;

  localparam logic [6:0] OP_ADDI   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_LW   = 3'b000;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_RS1    = 2'b01;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

  function automatic logic is_legal(input logic [6:0] opcode, input logic [2:0] funct3);
    logic ok;
    case (opcode)
      OP_ADDI:   ok = (funct3 == F3_ADDI);
      OP_LOAD:   ok = (funct3 == F3_LW);
      OP_STORE:  ok = (funct3 == F3_SW);
      OP_BRANCH: ok = (funct3 == F3_BEQ);
      OP_JAL:    ok = 1'b1;
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Unified instruction/data memory handshake: strobes and address select
// from the controller, completion (mem_ready) from the memory.
interface multicycle_controller_if;
  logic mem_read;
  logic mem_write;
  logic mem_addr_sel;
  logic mem_ready;

  modport master (output mem_read, output mem_write, output mem_addr_sel, input mem_ready);
  modport slave  (input mem_read, input mem_write, input mem_addr_sel, output mem_ready);
endinterface

// File: rtl/multicycle_controller_mem_timeout_counter.sv
// Memory wait watchdog: 8-bit counter cleared on entry to an access,
// bumped on every not-ready cycle, expired when it equals MEM_TIMEOUT.
module mem_timeout_counter #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT);

  logic [7:0] count;

  // Saturate rather than wrap so a stale count can never alias back to LIMIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 8'd0;
    end else if (clr) begin
      count <= 8'd0;
    end else if (inc && (count != 8'hFF)) begin
      count <= count + 8'd1;
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for addi, lw, sw, beq, jal.
// Memory accesses wait on mem_ready; a watchdog halts the core on a stuck access.
module multicycle_controller
  import riscv_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            run,
  input  logic [6:0]                      opcode,
  input  logic [2:0]                      funct3,
  input  logic                            alu_zero,
  multicycle_controller_if.master         mem,
  output logic                            ir_write,
  output logic                            pc_write,
  output logic                            pc_src,
  output logic [1:0]                      alu_src_a,
  output logic [1:0]                      alu_src_b,
  output logic [3:0]                      alu_ctrl,
  output logic                            reg_write,
  output logic [1:0]                      wb_sel,
  output logic                            instr_retired,
  output logic                            illegal,
  output logic                            timeout,
  output logic [2:0]                      state
);

  state_t cur_state, nxt_state;
  logic   mem_read_c, mem_write_c, mem_addr_sel_c;
  logic   retire, illegal_set, timeout_set;
  logic   cnt_clr, cnt_inc, cnt_expired;
  logic   illegal_q, timeout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= S_IDLE;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      illegal_q <= illegal_q | illegal_set;
      timeout_q <= timeout_q | timeout_set;
    end
  end

  always_comb begin
    nxt_state      = cur_state;
    mem_read_c     = 1'b0;
    mem_write_c    = 1'b0;
    mem_addr_sel_c = 1'b0;
    ir_write       = 1'b0;
    pc_write       = 1'b0;
    pc_src         = 1'b0;
    alu_src_a      = SRC_A_PC;
    alu_src_b      = SRC_B_RS2;
    alu_ctrl       = ALU_ADD;
    reg_write      = 1'b0;
    wb_sel         = WB_ALUOUT;
    retire         = 1'b0;
    illegal_set    = 1'b0;
    timeout_set    = 1'b0;

    case (cur_state)
      S_IDLE: begin
        if (run) nxt_state = S_FETCH;
      end
      S_FETCH: begin
        mem_read_c = 1'b1;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_FOUR;
        if (mem.mem_ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          nxt_state = S_DECODE;
        end else if (cnt_expired) begin
          timeout_set = 1'b1;
          nxt_state   = S_HALT;
        end
      end
      S_DECODE: begin
        // Branch/jal target lands in ALUOut while the opcode is checked.
        alu_src_a = SRC_A_OLD_PC;
        alu_src_b = SRC_B_IMM;
        if (is_legal(opcode, funct3)) begin
          nxt_state = S_EXEC;
        end else begin
          illegal_set = 1'b1;
          nxt_state   = S_HALT;
        end
      end
      S_EXEC: begin
        case (opcode)
          OP_ADDI, OP_LOAD, OP_STORE: begin
            alu_src_a = SRC_A_RS1;
            alu_src_b = SRC_B_IMM;
            nxt_state = (opcode == OP_ADDI) ? S_WB : S_MEM;
          end
          OP_BRANCH: begin
            alu_src_a = SRC_A_RS1;
            alu_src_b = SRC_B_RS2;
            alu_ctrl  = ALU_SUB;
            pc_src    = 1'b1;
            pc_write  = alu_zero;
            retire    = 1'b1;
          end
          OP_JAL: begin
            reg_write = 1'b1;
            wb_sel    = WB_PC;
            pc_write  = 1'b1;
            pc_src    = 1'b1;
            retire    = 1'b1;
          end
          default: nxt_state = S_HALT;
        endcase
      end
      S_MEM: begin
        mem_addr_sel_c = 1'b1;
        mem_read_c     = (opcode == OP_LOAD);
        mem_write_c    = (opcode == OP_STORE);
        if (mem.mem_ready) begin
          if (opcode == OP_LOAD) nxt_state = S_WB;
          else                   retire    = 1'b1;
        end else if (cnt_expired) begin
          timeout_set = 1'b1;
          nxt_state   = S_HALT;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        wb_sel    = (opcode == OP_LOAD) ? WB_MDR : WB_ALUOUT;
        retire    = 1'b1;
      end
      S_HALT: nxt_state = S_HALT;
      default: nxt_state = S_HALT;
    endcase

    if (retire) nxt_state = run ? S_FETCH : S_IDLE;
  end

  assign cnt_clr = ((nxt_state == S_FETCH) || (nxt_state == S_MEM)) && (nxt_state != cur_state);
  assign cnt_inc = ((cur_state == S_FETCH) || (cur_state == S_MEM)) && !mem.mem_ready;

  mem_timeout_counter #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (cnt_clr),
    .inc     (cnt_inc),
    .expired (cnt_expired)
  );

  assign mem.mem_read     = mem_read_c;
  assign mem.mem_write    = mem_write_c;
  assign mem.mem_addr_sel = mem_addr_sel_c;
  assign instr_retired    = retire;
  assign illegal          = illegal_q;
  assign timeout          = timeout_q;
  assign state            = cur_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: a cycle-by-cycle vector table plus
// hand sequences for illegal opcodes, watchdog, async reset and run control.
module tb_multicycle_controller;
  import riscv_pkg::*;

  typedef struct packed {
    logic [2:0] st;
    logic       mr, mw, mas, irw, pcw, pcs;
    logic [1:0] sa, sb;
    logic [3:0] ac;
    logic       rw;
    logic [1:0] wb;
    logic       ret, ill, to;
  } out_t;

  typedef struct {
    string      name;
    logic       run;
    logic [6:0] op;
    logic [2:0] f3;
    logic       z;
    logic       rdy;
    out_t       exp;
  } vec_t;

  logic clk, rst_n, run, alu_zero;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic ir_write, pc_write, pc_src, reg_write, instr_retired, illegal, timeout;
  logic [1:0] alu_src_a, alu_src_b, wb_sel;
  logic [3:0] alu_ctrl;
  logic [2:0] state;
  int tests, fails;
  vec_t vecs[$];
  out_t E_IDLE, F_RDY, F_WAIT, DEC, EX_ADD, WB_ADDI, WB_LW, BEQ_T, BEQ_N, JAL_E, MEM_SW, MEM_LW;

  multicycle_controller_if mem_if();

  multicycle_controller #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .funct3(funct3),
    .alu_zero(alu_zero), .mem(mem_if), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
    .reg_write(reg_write), .wb_sel(wb_sel), .instr_retired(instr_retired),
    .illegal(illegal), .timeout(timeout), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic out_t o(input logic [2:0] st, input logic mr, mw, mas, irw, pcw, pcs,
                             input logic [1:0] sa, sb, input logic [3:0] ac,
                             input logic rw, input logic [1:0] wb, input logic ret);
    out_t r;
    r = '{st, mr, mw, mas, irw, pcw, pcs, sa, sb, ac, rw, wb, ret, 1'b0, 1'b0};
    return r;
  endfunction

  task automatic chk(input string nm, input out_t e);
    out_t a;
    a = {state, mem_if.mem_read, mem_if.mem_write, mem_if.mem_addr_sel, ir_write, pc_write,
         pc_src, alu_src_a, alu_src_b, alu_ctrl, reg_write, wb_sel, instr_retired, illegal, timeout};
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic chk1(input string nm, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add_v(input string nm, input logic r, input logic [6:0] op, input logic [2:0] f,
                       input logic z, input logic rdy, input out_t e);
    vec_t v;
    v.name = nm; v.run = r; v.op = op; v.f3 = f; v.z = z; v.rdy = rdy; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; run = 1'b0; opcode = '0; funct3 = '0; alu_zero = 1'b0; mem_if.mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic illegal_seq(input string nm, input logic [6:0] op, input logic [2:0] f);
    do_reset();
    run = 1'b1; opcode = op; funct3 = f; mem_if.mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1({nm, "_halt"}, {4'd0, state, illegal}, {4'd0, 3'd6, 1'b1});
    for (int i = 0; i < 4; i++) begin
      chk1({nm, "_quiet"}, {2'd0, mem_if.mem_read, mem_if.mem_write, ir_write, pc_write, reg_write,
           instr_retired}, 8'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    rst_n = 1'b0; run = 1'b0; opcode = '0; funct3 = '0; alu_zero = 1'b0; mem_if.mem_ready = 1'b0;

    E_IDLE  = o(3'd0, 0,0,0,0,0,0, 2'b00,2'b00,4'h0, 0,2'b00,0);
    F_RDY   = o(3'd1, 1,0,0,1,1,0, 2'b00,2'b10,4'h0, 0,2'b00,0);
    F_WAIT  = o(3'd1, 1,0,0,0,0,0, 2'b00,2'b10,4'h0, 0,2'b00,0);
    DEC     = o(3'd2, 0,0,0,0,0,0, 2'b10,2'b01,4'h0, 0,2'b00,0);
    EX_ADD  = o(3'd3, 0,0,0,0,0,0, 2'b01,2'b01,4'h0, 0,2'b00,0);
    WB_ADDI = o(3'd5, 0,0,0,0,0,0, 2'b00,2'b00,4'h0, 1,2'b00,1);
    WB_LW   = o(3'd5, 0,0,0,0,0,0, 2'b00,2'b00,4'h0, 1,2'b01,1);
    BEQ_T   = o(3'd3, 0,0,0,0,1,1, 2'b01,2'b00,4'h1, 0,2'b00,1);
    BEQ_N   = o(3'd3, 0,0,0,0,0,1, 2'b01,2'b00,4'h1, 0,2'b00,1);
    JAL_E   = o(3'd3, 0,0,0,0,1,1, 2'b00,2'b00,4'h0, 1,2'b10,1);
    MEM_SW  = o(3'd4, 0,1,1,0,0,0, 2'b00,2'b00,4'h0, 0,2'b00,1);
    MEM_LW  = o(3'd4, 1,0,1,0,0,0, 2'b00,2'b00,4'h0, 0,2'b00,0);

    #2 chk("reset_state", E_IDLE);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    add_v("idle_run",  1, OP_ADDI,   3'b000, 0, 1, E_IDLE);
    add_v("addi_f",    1, OP_ADDI,   3'b000, 0, 1, F_RDY);
    add_v("addi_d",    1, OP_ADDI,   3'b000, 0, 1, DEC);
    add_v("addi_e",    1, OP_ADDI,   3'b000, 0, 1, EX_ADD);
    add_v("addi_wb",   1, OP_ADDI,   3'b000, 0, 1, WB_ADDI);
    add_v("beqt_f",    1, OP_BRANCH, 3'b000, 1, 1, F_RDY);
    add_v("beqt_d",    1, OP_BRANCH, 3'b000, 1, 1, DEC);
    add_v("beqt_e",    1, OP_BRANCH, 3'b000, 1, 1, BEQ_T);
    add_v("beqn_f",    1, OP_BRANCH, 3'b000, 0, 1, F_RDY);
    add_v("beqn_d",    1, OP_BRANCH, 3'b000, 0, 1, DEC);
    add_v("beqn_e",    1, OP_BRANCH, 3'b000, 0, 1, BEQ_N);
    add_v("jal_f",     1, OP_JAL,    3'b101, 0, 1, F_RDY);
    add_v("jal_d",     1, OP_JAL,    3'b101, 0, 1, DEC);
    add_v("jal_e",     1, OP_JAL,    3'b101, 0, 1, JAL_E);
    add_v("sw_fwait",  1, OP_STORE,  3'b010, 0, 0, F_WAIT);
    add_v("sw_f",      1, OP_STORE,  3'b010, 0, 1, F_RDY);
    add_v("sw_d",      1, OP_STORE,  3'b010, 0, 1, DEC);
    add_v("sw_e",      1, OP_STORE,  3'b010, 0, 1, EX_ADD);
    add_v("sw_mem",    1, OP_STORE,  3'b010, 0, 1, MEM_SW);
    add_v("lw_f",      1, OP_LOAD,   3'b000, 0, 1, F_RDY);
    add_v("lw_d",      1, OP_LOAD,   3'b000, 0, 1, DEC);
    add_v("lw_e",      1, OP_LOAD,   3'b000, 0, 1, EX_ADD);
    add_v("lw_mem1",   1, OP_LOAD,   3'b000, 0, 0, MEM_LW);
    add_v("lw_mem2",   1, OP_LOAD,   3'b000, 0, 0, MEM_LW);
    add_v("lw_mem3",   1, OP_LOAD,   3'b000, 0, 0, MEM_LW);
    add_v("lw_mem4",   1, OP_LOAD,   3'b000, 0, 1, MEM_LW);
    add_v("lw_wb",     0, OP_LOAD,   3'b000, 0, 1, WB_LW);
    add_v("lw_idle",   0, OP_LOAD,   3'b000, 0, 1, E_IDLE);
    add_v("idle_run2", 1, OP_ADDI,   3'b000, 0, 1, E_IDLE);
    add_v("stop_f",    1, OP_ADDI,   3'b000, 0, 1, F_RDY);
    add_v("stop_d",    1, OP_ADDI,   3'b000, 0, 1, DEC);
    add_v("stop_e",    0, OP_ADDI,   3'b000, 0, 1, EX_ADD);
    add_v("stop_wb",   0, OP_ADDI,   3'b000, 0, 1, WB_ADDI);
    add_v("stop_idle", 0, OP_ADDI,   3'b000, 0, 1, E_IDLE);

    foreach (vecs[i]) begin
      run = vecs[i].run; opcode = vecs[i].op; funct3 = vecs[i].f3;
      alu_zero = vecs[i].z; mem_if.mem_ready = vecs[i].rdy;
      @(negedge clk);
      chk(vecs[i].name, vecs[i].exp);
      @(posedge clk); #1;
    end

    illegal_seq("ill_rtype", 7'b0110011, 3'b000);
    illegal_seq("ill_lw_f3", OP_LOAD, 3'b001);

    // Watchdog: five not-ready FETCH cycles with a limit of 4, then HALT.
    do_reset();
    run = 1'b1; opcode = OP_ADDI; mem_if.mem_ready = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk1("to_fetch_wait", {4'd0, state, timeout}, {4'd0, 3'd1, 1'b0});
    end
    @(negedge clk);
    chk1("to_halt", {3'd0, state, timeout, mem_if.mem_read}, {3'd0, 3'd6, 1'b1, 1'b0});

    // mem_ready arriving in the limit cycle completes the fetch.
    do_reset();
    run = 1'b1; opcode = OP_ADDI; mem_if.mem_ready = 1'b0;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1 mem_if.mem_ready = 1'b1;
    @(negedge clk);
    chk1("to_late_rdy", {6'd0, ir_write, timeout}, {6'd0, 1'b1, 1'b0});
    @(posedge clk); #1;
    chk1("to_late_decode", {4'd0, state, timeout}, {4'd0, 3'd2, 1'b0});

    // Asynchronous reset while a store is waiting in MEM.
    do_reset();
    run = 1'b1; opcode = OP_STORE; funct3 = 3'b010; mem_if.mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 mem_if.mem_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk1("rst_pre_mem", {3'd0, state, mem_if.mem_write, mem_if.mem_addr_sel}, {3'd0, 3'd4, 1'b1, 1'b1});
    #1 rst_n = 1'b0;
    #1;
    chk1("rst_async", {2'd0, state, mem_if.mem_write, mem_if.mem_addr_sel, mem_if.mem_read},
         {2'd0, 3'd0, 1'b0, 1'b0, 1'b0});
    #3 rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
